fu_operand_sequencer: RTL

Operand register file and command sequencer that wraps the 8-bit functional unit. It holds three 8-bit operand registers (A, B, C) and drives them, with the instruction and select lines, into the functional unit. It then captures the functional unit's combinational result F and writes it back into a chosen operand register. Commands arrive over a valid/ready handshake, and every command reports completion with a one-cycle done pulse.

---
 rtl/fu_operand_sequencer_if.sv | 53 +++++
 rtl/fu_operand_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fu_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// fu_operand_sequencer_if
//
// Purpose: groups the host-side signals of fu_operand_sequencer, which are
//          the direct-load channel, the command channel and the status
//          outputs.
//
// Signals:
//   load_valid / load_ready  direct register write handshake
//   load_sel   [1:0]         write target: 00=A, 01=B, 10=C, 11=none
//   load_data  [WIDTH-1:0]   value for a direct write
//   cmd_valid / cmd_ready    command handshake
//   cmd_instr  [7:0]         instruction forwarded to the functional unit
//   cmd_select [2:0]         operand-pair select forwarded to the unit
//   cmd_dest   [1:0]         write-back target: 00=A, 01=B, 10=C, 11=discard
//   result     [WIDTH-1:0]   last captured functional-unit result
//   done                     one-cycle completion pulse
//   busy                     sequencer is not idle
//
// Modports:
//   master  is the host side and drives the requests.
//   slave   is the sequencer side and drives ready, result, done and busy.
// ---------------------------------------------------------------------------
interface fu_operand_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic [1:0]       load_sel;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_instr;
  logic [2:0]       cmd_select;
  logic [1:0]       cmd_dest;

  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (
    output load_valid, load_sel, load_data,
    output cmd_valid, cmd_instr, cmd_select, cmd_dest,
    input  load_ready, cmd_ready, result, done, busy
  );

  modport slave (
    input  load_valid, load_sel, load_data,
    input  cmd_valid, cmd_instr, cmd_select, cmd_dest,
    output load_ready, cmd_ready, result, done, busy
  );
endinterface

// File: rtl/fu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// fu_operand_sequencer
//
// Purpose: operand register file (A, B, C) and three-state command sequencer
//          wrapped around the 8-bit combinational functional unit.
//          - IDLE  accepts direct loads and commands.
//          - ISSUE presents the latched instruction and select to the unit
//                  and captures F into result.
//          - WRITE writes result back to the latched destination and
//                  pulses done.
//          Handshake in cycle N gives done in N+2, and the new register value
//          is visible in N+3.
//
// Parameters:
//   WIDTH           datapath width (only 8 is supported by the unit)
//   INIT_A/B/C      reset values of the operand registers
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   bus             fu_operand_sequencer_if.slave (load/cmd/status)
//   fu_instruction  latched instruction to the unit (holds in IDLE)
//   fu_A/fu_B/fu_C  live operand registers to the unit
//   fu_select       latched operand-pair select to the unit (holds in IDLE)
//   fu_F            combinational result from the unit
//
// Optional build macro FU_SEQ_STATUS_EN adds:
//   zero_flag       (result == 0), registered in WRITE of non-NOP commands
//   op_count        8-bit wrapping count of done pulses
// ---------------------------------------------------------------------------
module fu_operand_sequencer #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] INIT_A = '0,
  parameter logic [WIDTH-1:0] INIT_B = '0,
  parameter logic [WIDTH-1:0] INIT_C = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fu_operand_sequencer_if.slave bus,
  output logic [7:0]            fu_instruction,
  output logic [WIDTH-1:0]      fu_A,
  output logic [WIDTH-1:0]      fu_B,
  output logic [WIDTH-1:0]      fu_C,
  output logic [2:0]            fu_select,
  input  logic [WIDTH-1:0]      fu_F
`ifdef FU_SEQ_STATUS_EN
  ,
  output logic                  zero_flag,
  output logic [7:0]            op_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Register selector encoding shared by load_sel and cmd_dest (11 = none).
  typedef enum logic [1:0] {
    REG_A    = 2'b00,
    REG_B    = 2'b01,
    REG_C    = 2'b10,
    REG_NONE = 2'b11
  } reg_sel_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [7:0]       instr_q, instr_d;
  logic [2:0]       select_q, select_d;
  reg_sel_e         dest_q, dest_d;
  logic [WIDTH-1:0] result_q, result_d;

`ifdef FU_SEQ_STATUS_EN
  logic             zero_q, zero_d;
  logic [7:0]       count_q, count_d;
`endif

  logic is_idle;
  logic load_fire;
  logic cmd_fire;
  logic is_nop;

  assign is_idle   = (state_q == ST_IDLE);
  assign load_fire = is_idle && bus.load_valid;
  assign cmd_fire  = is_idle && bus.cmd_valid;
  assign is_nop    = (instr_q == 8'h00);

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a hold default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    instr_d  = instr_q;
    select_d = select_q;
    dest_d   = dest_q;
    result_d = result_q;
`ifdef FU_SEQ_STATUS_EN
    zero_d   = zero_q;
    count_d  = count_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // A load in the same cycle as a command lands at this edge, so the
        // following ISSUE cycle already drives the loaded value.
        if (load_fire) begin
          unique case (reg_sel_e'(bus.load_sel))
            REG_A:    a_d = bus.load_data;
            REG_B:    b_d = bus.load_data;
            REG_C:    c_d = bus.load_data;
            REG_NONE: ;
            default:  ;
          endcase
        end
        if (cmd_fire) begin
          instr_d  = bus.cmd_instr;
          select_d = bus.cmd_select;
          dest_d   = reg_sel_e'(bus.cmd_dest);
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // A NOP keeps the previous result so that it is visible again at done.
        if (!is_nop) begin
          result_d = fu_F;
        end
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        if (!is_nop) begin
          unique case (dest_q)
            REG_A:    a_d = result_q;
            REG_B:    b_d = result_q;
            REG_C:    c_d = result_q;
            REG_NONE: ;
            default:  ;
          endcase
`ifdef FU_SEQ_STATUS_EN
          zero_d = (result_q == '0);
`endif
        end
`ifdef FU_SEQ_STATUS_EN
        count_d = count_q + 8'd1;
`endif
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples its pre-edge value, and there is no ordering race between
  // processes.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the three operand registers form a tiny architectural register
      // file with defined INIT values. They are reset like control state,
      // unlike a RAM array whose contents would stay unreset.
      state_q  <= ST_IDLE;
      a_q      <= INIT_A;
      b_q      <= INIT_B;
      c_q      <= INIT_C;
      instr_q  <= 8'h00;
      select_q <= 3'b000;
      dest_q   <= REG_NONE;
      result_q <= '0;
`ifdef FU_SEQ_STATUS_EN
      zero_q   <= 1'b0;
      count_q  <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      instr_q  <= instr_d;
      select_q <= select_d;
      dest_q   <= dest_d;
      result_q <= result_d;
`ifdef FU_SEQ_STATUS_EN
      zero_q   <= zero_d;
      count_q  <= count_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.load_ready = is_idle;
  assign bus.cmd_ready  = is_idle;
  assign bus.busy       = !is_idle;
  assign bus.result     = result_q;
  // Gating with rst suppresses done when a reset arrives during WRITE.
  assign bus.done       = (state_q == ST_WRITE) && !rst;

  assign fu_instruction = instr_q;
  assign fu_select      = select_q;
  assign fu_A           = a_q;
  assign fu_B           = b_q;
  assign fu_C           = c_q;

`ifdef FU_SEQ_STATUS_EN
  assign zero_flag = zero_q;
  assign op_count  = count_q;
`endif

endmodule
